// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG coefficient generator: FSM encoding, run/length
// special codes and the magnitude EXTEND helper.
package jpeg_pkg;

  typedef enum logic [3:0] {
    StDcHuff,
    StDcBits,
    StDcEmit,
    StAcHuff,
    StAcBits,
    StZeroRun,
    StAcEmit,
    StEobFill,
    StErr
  } state_e;

  localparam int unsigned CODE_W     = 16;
  localparam logic [5:0]  BLOCK_LAST = 6'd63;
  localparam logic [3:0]  EOB_RUN    = 4'd0;
  localparam logic [3:0]  ZRL_RUN    = 4'd15;
  localparam logic [4:0]  ZRL_ZEROS  = 5'd16;

  // Codes with a leading 0 encode negative values offset by (2^size - 1).
  function automatic logic signed [31:0] extend_mag(input logic [3:0]        size,
                                                    input logic [CODE_W-1:0] code);
    logic [31:0] w_code;
    w_code = 32'(code);
    if (size == 4'd0) begin
      return '0;
    end
    if (code[size - 4'd1]) begin
      return signed'(w_code);
    end
    return signed'(w_code - ((32'd1 << size) - 32'd1));
  endfunction

endpackage

// File: rtl/jpeg_magnitude_extend.sv
// Combinational magnitude decoder: turns a size/code pair into a signed COEF_W value.
module jpeg_magnitude_extend
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = 12
) (
  input  logic [3:0]        i_size,
  input  logic [CODE_W-1:0] i_code,
  output logic [COEF_W-1:0] o_value
);

  assign o_value = COEF_W'(extend_mag(i_size, i_code));

endmodule

// File: rtl/jpeg_coefficient_generator.sv
// Decodes one 8x8 block of entropy-coded bits into 64 zig-zag coefficients, with per-component
// DC prediction, zero runs, ZRL and EOB fill; Huffman symbols come from an external decoder.
module jpeg_coefficient_generator
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W   = 12,
  parameter int unsigned MAX_SIZE = 11,
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned COMP_W   = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [COMP_W-1:0] comp_sel,
  input  logic              bit_input,
  input  logic              is_new_bit,
  output logic              bit_ready,
  output logic              ac_dc_huffman,
  output logic              bit_huffman,
  output logic              is_new_bit_huffman,
  input  logic [3:0]        r_value_huffman,
  input  logic [3:0]        s_value_huffman,
  input  logic              done_huffman,
  output logic [COEF_W-1:0] coefficient,
  output logic [5:0]        coef_index,
  output logic              is_new_coefficient,
  output logic              block_done,
  output logic              error
);

  state_e            r_state, w_state_next;
  logic [5:0]        r_index, w_index_next;
  logic [4:0]        r_run, w_run_next;
  logic [3:0]        r_size, w_size_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [CODE_W-1:0] r_code, w_code_next, w_shift;
  logic [COMP_W-1:0] r_comp, w_comp_next;
  logic              r_started, w_started_next;
  logic              r_wait;
  logic [COEF_W-1:0] r_value, w_value_next, w_ext;
  logic [COEF_W-1:0] r_pred [NUM_COMP];
  logic [COEF_W-1:0] w_pred_next [NUM_COMP];
  logic              w_in_huff, w_in_bits, w_accept, w_last_bit;

  assign w_shift = (r_code << 1) | CODE_W'(bit_input);

  jpeg_magnitude_extend #(
    .COEF_W (COEF_W)
  ) u_extend (
    .i_size  (r_size),
    .i_code  (w_shift),
    .o_value (w_ext)
  );

  // Bit handshake; the Huffman decoder needs one idle cycle after each forwarded bit.
  always_comb begin
    w_in_huff          = (r_state == StDcHuff) || (r_state == StAcHuff);
    w_in_bits          = (r_state == StDcBits) || (r_state == StAcBits);
    bit_ready          = ((w_in_huff && !r_wait) || w_in_bits) && !restart;
    w_accept           = is_new_bit && bit_ready;
    ac_dc_huffman      = (r_state == StAcHuff);
    bit_huffman        = w_in_huff ? bit_input : 1'b0;
    is_new_bit_huffman = w_accept && w_in_huff;
    w_last_bit         = w_accept && w_in_bits && (r_cnt == r_size - 4'd1);
  end

  always_comb begin
    w_state_next   = r_state;
    w_index_next   = r_index;
    w_run_next     = r_run;
    w_size_next    = r_size;
    w_cnt_next     = r_cnt;
    w_code_next    = r_code;
    w_comp_next    = r_comp;
    w_started_next = r_started;
    w_value_next   = r_value;
    w_pred_next    = r_pred;

    unique case (r_state)
      StDcHuff: begin
        if (w_accept && !r_started) begin
          w_comp_next    = comp_sel;
          w_started_next = 1'b1;
          if (32'(comp_sel) >= NUM_COMP) begin
            w_state_next = StErr;
          end
        end
        if (done_huffman) begin
          w_size_next = r_value_huffman;
          w_cnt_next  = '0;
          w_code_next = '0;
          if (r_value_huffman == 4'd0) begin
            w_state_next = StDcEmit;
          end else if (32'(r_value_huffman) > MAX_SIZE) begin
            w_state_next = StErr;
          end else begin
            w_state_next = StDcBits;
          end
        end
      end
      StDcBits, StAcBits: begin
        if (w_accept) begin
          w_code_next = w_shift;
          w_cnt_next  = r_cnt + 4'd1;
        end
        if (w_last_bit) begin
          if (r_state == StDcBits) begin
            w_pred_next[r_comp] = r_pred[r_comp] + w_ext;
            w_state_next        = StDcEmit;
          end else begin
            w_value_next = w_ext;
            w_state_next = StAcEmit;
          end
        end
      end
      StDcEmit: begin
        w_index_next   = 6'd1;
        w_started_next = 1'b0;
        w_state_next   = StAcHuff;
      end
      StAcHuff: begin
        if (done_huffman) begin
          w_cnt_next  = '0;
          w_code_next = '0;
          if (r_value_huffman == 4'd0) begin
            if (s_value_huffman == EOB_RUN) begin
              w_state_next = StEobFill;
            end else if (s_value_huffman == ZRL_RUN &&
                         (7'(r_index) + 7'd15 <= 7'(BLOCK_LAST))) begin
              w_run_next   = ZRL_ZEROS;
              w_size_next  = '0;
              w_state_next = StZeroRun;
            end else begin
              w_state_next = StErr;
            end
          end else if (32'(r_value_huffman) > MAX_SIZE ||
                       (7'(r_index) + 7'(s_value_huffman) > 7'(BLOCK_LAST))) begin
            w_state_next = StErr;
          end else begin
            w_size_next  = r_value_huffman;
            w_run_next   = 5'(s_value_huffman);
            w_state_next = (s_value_huffman != 4'd0) ? StZeroRun : StAcBits;
          end
        end
      end
      StZeroRun: begin
        w_index_next = r_index + 6'd1;
        w_run_next   = r_run - 5'd1;
        if (r_run == 5'd1) begin
          if (r_size != 4'd0) begin
            w_state_next = StAcBits;
          end else begin
            w_state_next = (r_index == BLOCK_LAST) ? StDcHuff : StAcHuff;
          end
        end
      end
      StAcEmit: begin
        w_index_next = r_index + 6'd1;
        w_state_next = (r_index == BLOCK_LAST) ? StDcHuff : StAcHuff;
      end
      StEobFill: begin
        w_index_next = r_index + 6'd1;
        if (r_index == BLOCK_LAST) begin
          w_state_next = StDcHuff;
        end
      end
      StErr: begin
        w_state_next = StErr;
      end
      default: begin
        w_state_next = StErr;
      end
    endcase

    if (restart) begin
      w_state_next   = StDcHuff;
      w_index_next   = '0;
      w_run_next     = '0;
      w_cnt_next     = '0;
      w_started_next = 1'b0;
      for (int i = 0; i < int'(NUM_COMP); i++) begin
        w_pred_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StDcHuff;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index   <= '0;
      r_run     <= '0;
      r_size    <= '0;
      r_cnt     <= '0;
      r_code    <= '0;
      r_comp    <= '0;
      r_started <= 1'b0;
      r_wait    <= 1'b0;
      r_value   <= '0;
      for (int i = 0; i < int'(NUM_COMP); i++) begin
        r_pred[i] <= '0;
      end
    end else begin
      r_index   <= w_index_next;
      r_run     <= w_run_next;
      r_size    <= w_size_next;
      r_cnt     <= w_cnt_next;
      r_code    <= w_code_next;
      r_comp    <= w_comp_next;
      r_started <= w_started_next;
      r_wait    <= is_new_bit_huffman;
      r_value   <= w_value_next;
      r_pred    <= w_pred_next;
    end
  end

  // Emission is a function of state; a restart cycle never reports a coefficient.
  always_comb begin
    coefficient        = '0;
    coef_index         = '0;
    is_new_coefficient = 1'b0;
    unique case (r_state)
      StDcEmit: begin
        coefficient        = r_pred[r_comp];
        is_new_coefficient = !restart;
      end
      StZeroRun, StEobFill: begin
        coef_index         = r_index;
        is_new_coefficient = !restart;
      end
      StAcEmit: begin
        coefficient        = r_value;
        coef_index         = r_index;
        is_new_coefficient = !restart;
      end
      default: ;
    endcase
    block_done = is_new_coefficient && (coef_index == BLOCK_LAST) && (r_state != StDcEmit);
    error      = (r_state == StErr);
  end

endmodule

// File: tb/tb_jpeg_coefficient_generator.sv
// Scoreboard bench: symbol-level stimulus feeds a block model that queues expected
// coefficients; a monitor pops and compares whenever the generator emits one.
`timescale 1ns/1ps
module tb_jpeg_coefficient_generator;

  typedef struct packed {
    logic [11:0] coef;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, restart;
  logic [1:0]  comp_sel;
  logic        bit_input, is_new_bit, bit_ready;
  logic        ac_dc_huffman, bit_huffman, is_new_bit_huffman;
  logic [3:0]  r_value_huffman, s_value_huffman;
  logic        done_huffman;
  logic [11:0] coefficient;
  logic [5:0]  coef_index;
  logic        is_new_coefficient, block_done, error;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          tb_pos  = 0;
  logic [11:0] tb_pred [3];

  always #5 clk = ~clk;

  jpeg_coefficient_generator #(
    .COEF_W   (12),
    .MAX_SIZE (11),
    .NUM_COMP (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .restart            (restart),
    .comp_sel           (comp_sel),
    .bit_input          (bit_input),
    .is_new_bit         (is_new_bit),
    .bit_ready          (bit_ready),
    .ac_dc_huffman      (ac_dc_huffman),
    .bit_huffman        (bit_huffman),
    .is_new_bit_huffman (is_new_bit_huffman),
    .r_value_huffman    (r_value_huffman),
    .s_value_huffman    (s_value_huffman),
    .done_huffman       (done_huffman),
    .coefficient        (coefficient),
    .coef_index         (coef_index),
    .is_new_coefficient (is_new_coefficient),
    .block_done         (block_done),
    .error              (error)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: JPEG magnitude category and its encoded bit pattern.
  function automatic int cat(input int v);
    int a = (v < 0) ? -v : v;
    int s = 0;
    while (a != 0) begin
      a = a >> 1;
      s++;
    end
    return s;
  endfunction

  function automatic logic [15:0] enc(input int v, input int s);
    int c = (v < 0) ? v + (1 << s) - 1 : v;
    return 16'(c);
  endfunction

  function automatic int rand_val(input int s);
    int mag;
    if (s == 0) return 0;
    mag = int'($urandom_range((1 << s) - 1, 1 << (s - 1)));
    return ($urandom_range(1, 0) != 0) ? mag : -mag;
  endfunction

  task automatic push_coef(input logic [11:0] c);
    q.push_back('{coef: c, idx: 6'(tb_pos), last: (tb_pos == 63)});
    tb_pos = (tb_pos == 63) ? 0 : tb_pos + 1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) tb_pred[i] = '0;
    tb_pos = 0;
  endtask

  task automatic send_bit(input logic b, input logic is_huff, input logic exp_ac);
    int n = 0;
    @(negedge clk);
    bit_input  = b;
    is_new_bit = 1'b1;
    #1;
    while (!bit_ready) begin
      n++;
      if (n > 200) begin
        chk("bit_ready_timeout", 0, 1);
        is_new_bit = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    if (is_huff) begin
      chk("fwd_valid", is_new_bit_huffman, 1);
      chk("fwd_table", ac_dc_huffman, exp_ac);
      chk("fwd_bit", bit_huffman, b);
    end else begin
      chk("mag_not_forwarded", is_new_bit_huffman, 0);
    end
    @(posedge clk);
  endtask

  // Emulates the Huffman decoder: random code bits, then done one cycle after the last one.
  task automatic send_code(input logic exp_ac, input logic [3:0] r, input logic [3:0] s);
    int len = int'($urandom_range(4, 1));
    for (int i = 0; i < len; i++) send_bit(1'($urandom_range(1, 0)), 1'b1, exp_ac);
    @(negedge clk);
    is_new_bit      = 1'b0;
    done_huffman    = 1'b1;
    r_value_huffman = r;
    s_value_huffman = s;
    @(negedge clk);
    done_huffman = 1'b0;
  endtask

  task automatic send_mag(input int s, input logic [15:0] code);
    for (int i = s - 1; i >= 0; i--) send_bit(code[i], 1'b0, 1'b0);
    @(negedge clk);
    is_new_bit = 1'b0;
  endtask

  task automatic send_dc(input int comp, input int diff);
    int s = cat(diff);
    tb_pred[comp] = tb_pred[comp] + 12'(diff);
    q.push_back('{coef: tb_pred[comp], idx: 6'd0, last: 1'b0});
    tb_pos   = 1;
    comp_sel = 2'(comp);
    send_code(1'b0, 4'(s), 4'd0);
    if (s > 0) send_mag(s, enc(diff, s));
  endtask

  task automatic send_ac(input int run, input int v);
    int s = cat(v);
    for (int i = 0; i < run; i++) push_coef('0);
    push_coef(12'(v));
    send_code(1'b1, 4'(s), 4'(run));
    send_mag(s, enc(v, s));
  endtask

  task automatic send_zrl();
    for (int i = 0; i < 16; i++) push_coef('0);
    send_code(1'b1, 4'd0, 4'd15);
  endtask

  task automatic send_eob();
    do push_coef('0); while (tb_pos != 0);
    send_code(1'b1, 4'd0, 4'd0);
  endtask

  task automatic random_block();
    int comp = int'($urandom_range(2, 0));
    send_dc(comp, rand_val(int'($urandom_range(11, 0))));
    while (tb_pos != 0) begin
      int r = int'($urandom_range(9, 0));
      if (r == 0) begin
        send_eob();
      end else if (r == 1 && tb_pos + 15 <= 63) begin
        send_zrl();
      end else begin
        int mr = 63 - tb_pos;
        if (mr > 15) mr = 15;
        if (mr > 3 && $urandom_range(3, 0) != 0) mr = 3;
        send_ac(int'($urandom_range(mr, 0)), rand_val(int'($urandom_range(10, 1))));
      end
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (is_new_coefficient) begin
        if (q.size() == 0) begin
          chk("unexpected_coef_at_index", coef_index, 64);
        end else begin
          e = q.pop_front();
          chk("coef_value", coefficient, e.coef);
          chk("coef_index", coef_index, e.idx);
          chk("block_done", block_done, e.last);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; restart = 1'b0; comp_sel = '0; bit_input = 1'b0; is_new_bit = 1'b0;
    r_value_huffman = '0; s_value_huffman = '0; done_huffman = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_coef", coefficient, 0);
    chk("rst_index", coef_index, 0);
    chk("rst_valid", is_new_coefficient, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_error", error, 0);
    chk("rst_fwd_valid", is_new_bit_huffman, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_bit_ready", bit_ready, 1);

    // Directed blocks
    send_dc(0, 2);   send_eob();
    send_dc(0, -2);  send_eob();
    send_dc(1, -4);  send_eob();
    send_dc(0, 7);   send_ac(2, -1); send_eob();
    send_dc(2, 0);   send_zrl(); send_zrl(); send_zrl(); send_ac(14, 1);
    send_dc(1, 100); send_zrl(); send_zrl(); send_ac(14, -3); send_zrl();

    // Run overflowing index 63 from position 50
    send_dc(0, 5); send_zrl(); send_zrl(); send_zrl(); send_ac(0, 5);
    send_code(1'b1, 4'd4, 4'd15);
    repeat (3) @(negedge clk);
    #1;
    chk("err_set", error, 1);
    chk("err_queue_empty", q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      is_new_bit = 1'b1;
      #1;
      chk("err_bit_ready", bit_ready, 0);
      chk("err_no_fwd", is_new_bit_huffman, 0);
      chk("err_sticky", error, 1);
    end
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    is_new_bit = 1'b0;
    model_clear();
    #1;
    chk("restart_clears_err", error, 0);

    // Restart beats a simultaneous bit
    @(negedge clk);
    restart = 1'b1; is_new_bit = 1'b1; bit_input = 1'b1;
    #1;
    chk("restart_bit_ready", bit_ready, 0);
    chk("restart_drops_bit", is_new_bit_huffman, 0);
    @(negedge clk);
    restart = 1'b0; is_new_bit = 1'b0;

    // Async reset in the middle of a zero run
    send_dc(0, 3);
    for (int i = 0; i < 10; i++) push_coef('0);
    send_code(1'b1, 4'd1, 4'd10);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    model_clear();
    #1;
    chk("midrst_coef", coefficient, 0);
    chk("midrst_index", coef_index, 0);
    chk("midrst_valid", is_new_coefficient, 0);
    chk("midrst_block_done", block_done, 0);
    chk("midrst_error", error, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_dc(0, 1); send_eob();

    for (int b = 0; b < 20; b++) random_block();

    w = 0;
    while (q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
